// File: rtl/pipeline_pkg.sv
// Shared widths and encodings for the ID/EX operand stage and its forwarding muxes.
package pipeline_pkg;

   localparam int XLEN = 32;
   localparam int REGW = 5;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b10,
      FWD_WB  = 2'b01
   } fwd_sel_e;

endpackage

// File: rtl/forward_mux.sv
// Selects the freshest value for one source register: EX/MEM, then MEM/WB, then the register file.
module forward_mux
   import pipeline_pkg::*;
#(
   parameter int XLEN_P = XLEN,
   parameter int REGW_P = REGW
) (
   input  logic [REGW_P-1:0] src_i,
   input  logic [XLEN_P-1:0] reg_val_i,
   input  logic              m_reg_write_i,
   input  logic [REGW_P-1:0] m_rd_i,
   input  logic [XLEN_P-1:0] m_result_i,
   input  logic              w_reg_write_i,
   input  logic [REGW_P-1:0] w_rd_i,
   input  logic [XLEN_P-1:0] w_result_i,
   output logic [XLEN_P-1:0] val_o,
   output logic [1:0]        sel_o
);

   logic src_nonzero;
   assign src_nonzero = (src_i != '0);

   always_comb begin
      val_o = reg_val_i;
      sel_o = FWD_REG;
      // x0 is hardwired to zero, so a write aimed at it must never be forwarded.
      if (src_nonzero && m_reg_write_i && (m_rd_i == src_i)) begin
         val_o = m_result_i;
         sel_o = FWD_MEM;
      end else if (src_nonzero && w_reg_write_i && (w_rd_i == src_i)) begin
         val_o = w_result_i;
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with stall/flush, feeding forwarded operands to the execute ALU.
module id_ex_operand_stage
   import pipeline_pkg::*;
#(
   parameter int XLEN_P = XLEN,
   parameter int REGW_P = REGW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              d_valid,
   input  logic [XLEN_P-1:0] d_rd1,
   input  logic [XLEN_P-1:0] d_rd2,
   input  logic [XLEN_P-1:0] d_imm,
   input  logic [REGW_P-1:0] d_rs1,
   input  logic [REGW_P-1:0] d_rs2,
   input  logic [REGW_P-1:0] d_rd,
   input  logic [2:0]        d_alu_control,
   input  logic              d_alu_src,
   input  logic              d_reg_write,
   input  logic [REGW_P-1:0] m_rd,
   input  logic              m_reg_write,
   input  logic [XLEN_P-1:0] m_result,
   input  logic [REGW_P-1:0] w_rd,
   input  logic              w_reg_write,
   input  logic [XLEN_P-1:0] w_result,
   output logic [XLEN_P-1:0] alu_a,
   output logic [XLEN_P-1:0] alu_b,
   output logic [2:0]        e_alu_control,
   output logic [XLEN_P-1:0] e_store_data,
   output logic [REGW_P-1:0] e_rd,
   output logic              e_reg_write,
   output logic              e_valid,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
);

   logic              valid_q,     valid_d;
   logic              reg_write_q, reg_write_d;
   logic              alu_src_q,   alu_src_d;
   logic [2:0]        alu_ctl_q,   alu_ctl_d;
   logic [REGW_P-1:0] rs1_q,       rs1_d;
   logic [REGW_P-1:0] rs2_q,       rs2_d;
   logic [REGW_P-1:0] rd_q,        rd_d;
   logic [XLEN_P-1:0] rd1_q,       rd1_d;
   logic [XLEN_P-1:0] rd2_q,       rd2_d;
   logic [XLEN_P-1:0] imm_q,       imm_d;

   // Only decode-side inputs reach the next-state logic; m_/w_ feed outputs only.
   always_comb begin
      valid_d     = valid_q;
      reg_write_d = reg_write_q;
      alu_src_d   = alu_src_q;
      alu_ctl_d   = alu_ctl_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rd_d        = rd_q;
      rd1_d       = rd1_q;
      rd2_d       = rd2_q;
      imm_d       = imm_q;
      if (flush) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
         alu_src_d   = 1'b0;
         alu_ctl_d   = ALU_ADD;
         rs1_d       = '0;
         rs2_d       = '0;
         rd_d        = '0;
         rd1_d       = '0;
         rd2_d       = '0;
         imm_d       = '0;
      end else if (!stall) begin
         valid_d     = d_valid;
         reg_write_d = d_reg_write & d_valid;
         alu_src_d   = d_alu_src;
         alu_ctl_d   = d_alu_control;
         rs1_d       = d_rs1;
         rs2_d       = d_rs2;
         rd_d        = d_rd;
         rd1_d       = d_rd1;
         rd2_d       = d_rd2;
         imm_d       = d_imm;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         alu_src_q   <= 1'b0;
         alu_ctl_q   <= ALU_ADD;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         rd1_q       <= '0;
         rd2_q       <= '0;
         imm_q       <= '0;
      end else begin
         valid_q     <= valid_d;
         reg_write_q <= reg_write_d;
         alu_src_q   <= alu_src_d;
         alu_ctl_q   <= alu_ctl_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         rd1_q       <= rd1_d;
         rd2_q       <= rd2_d;
         imm_q       <= imm_d;
      end
   end

   logic [XLEN_P-1:0] fwd_rs1_val;
   logic [XLEN_P-1:0] fwd_rs2_val;

   forward_mux #(.XLEN_P(XLEN_P), .REGW_P(REGW_P)) u_fwd_rs1 (
      .src_i         (rs1_q),
      .reg_val_i     (rd1_q),
      .m_reg_write_i (m_reg_write),
      .m_rd_i        (m_rd),
      .m_result_i    (m_result),
      .w_reg_write_i (w_reg_write),
      .w_rd_i        (w_rd),
      .w_result_i    (w_result),
      .val_o         (fwd_rs1_val),
      .sel_o         (fwd_a)
   );

   forward_mux #(.XLEN_P(XLEN_P), .REGW_P(REGW_P)) u_fwd_rs2 (
      .src_i         (rs2_q),
      .reg_val_i     (rd2_q),
      .m_reg_write_i (m_reg_write),
      .m_rd_i        (m_rd),
      .m_result_i    (m_result),
      .w_reg_write_i (w_reg_write),
      .w_rd_i        (w_rd),
      .w_result_i    (w_result),
      .val_o         (fwd_rs2_val),
      .sel_o         (fwd_b)
   );

   assign alu_a         = fwd_rs1_val;
   assign alu_b         = alu_src_q ? imm_q : fwd_rs2_val;
   assign e_store_data  = fwd_rs2_val;
   assign e_alu_control = alu_ctl_q;
   assign e_rd          = rd_q;
   assign e_reg_write   = reg_write_q;
   assign e_valid       = valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: vector table plus stall/flush/reset sequences.
module tb_id_ex_operand_stage;

   logic        clk, reset, stall, flush;
   logic        d_valid, d_alu_src, d_reg_write;
   logic [31:0] d_rd1, d_rd2, d_imm;
   logic [4:0]  d_rs1, d_rs2, d_rd;
   logic [2:0]  d_alu_control;
   logic [4:0]  m_rd, w_rd;
   logic        m_reg_write, w_reg_write;
   logic [31:0] m_result, w_result;
   logic [31:0] alu_a, alu_b, e_store_data;
   logic [2:0]  e_alu_control;
   logic [4:0]  e_rd;
   logic        e_reg_write, e_valid;
   logic [1:0]  fwd_a, fwd_b;

   int checks = 0;
   int errors = 0;

   id_ex_operand_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .d_valid(d_valid), .d_rd1(d_rd1), .d_rd2(d_rd2), .d_imm(d_imm),
      .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
      .d_alu_control(d_alu_control), .d_alu_src(d_alu_src), .d_reg_write(d_reg_write),
      .m_rd(m_rd), .m_reg_write(m_reg_write), .m_result(m_result),
      .w_rd(w_rd), .w_reg_write(w_reg_write), .w_result(w_result),
      .alu_a(alu_a), .alu_b(alu_b), .e_alu_control(e_alu_control),
      .e_store_data(e_store_data), .e_rd(e_rd), .e_reg_write(e_reg_write),
      .e_valid(e_valid), .fwd_a(fwd_a), .fwd_b(fwd_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        valid, regw, alu_src;
      logic [2:0]  ctl;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] rd1, rd2, imm;
      logic        mrw;
      logic [4:0]  mrd;
      logic [31:0] mres;
      logic        wrw;
      logic [4:0]  wrd;
      logic [31:0] wres;
      logic [31:0] ea, eb, es;
      logic [1:0]  fa, fb;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      d_valid = v.valid; d_reg_write = v.regw; d_alu_src = v.alu_src;
      d_alu_control = v.ctl; d_rs1 = v.rs1; d_rs2 = v.rs2; d_rd = v.rd;
      d_rd1 = v.rd1; d_rd2 = v.rd2; d_imm = v.imm;
      m_reg_write = v.mrw; m_rd = v.mrd; m_result = v.mres;
      w_reg_write = v.wrw; w_rd = v.wrd; w_result = v.wres;
   endtask

   task automatic chk_ctrl(input string tag, input logic ev, input logic erw,
                           input logic [4:0] erd, input logic [2:0] ectl);
      chk({tag, ".e_valid"}, {31'b0, e_valid}, {31'b0, ev});
      chk({tag, ".e_reg_write"}, {31'b0, e_reg_write}, {31'b0, erw});
      chk({tag, ".e_rd"}, {27'b0, e_rd}, {27'b0, erd});
      chk({tag, ".e_alu_control"}, {29'b0, e_alu_control}, {29'b0, ectl});
   endtask

   initial begin
      // fields: valid regw alu_src ctl rs1 rs2 rd rd1 rd2 imm mrw mrd mres wrw wrd wres ea eb es fa fb
      vecs[0] = '{1,1,1,3'b000, 3, 4, 7, 32'h10, 32'h20, 32'hFFFF_FFFC, 0,0,32'h0, 0,0,32'h0,
                  32'h10, 32'hFFFF_FFFC, 32'h20, 2'b00, 2'b00};
      vecs[1] = '{1,1,0,3'b001, 5, 6, 8, 32'h11, 32'h22, 32'h0, 1,5,32'hAA, 1,5,32'hBB,
                  32'hAA, 32'h22, 32'h22, 2'b10, 2'b00};
      vecs[2] = '{1,1,0,3'b001, 5, 6, 8, 32'h11, 32'h22, 32'h0, 0,5,32'hAA, 1,5,32'hBB,
                  32'hBB, 32'h22, 32'h22, 2'b01, 2'b00};
      vecs[3] = '{1,0,0,3'b000, 1, 0, 2, 32'h1, 32'h0, 32'h0, 1,0,32'h55, 1,0,32'h66,
                  32'h1, 32'h0, 32'h0, 2'b00, 2'b00};
      vecs[4] = '{1,1,1,3'b010, 8, 8, 9, 32'h100, 32'h200, 32'h7, 1,8,32'hDEAD, 1,8,32'hBEEF,
                  32'hDEAD, 32'h7, 32'hDEAD, 2'b10, 2'b10};
      vecs[5] = '{1,1,0,3'b101, 9, 10, 11, 32'h9, 32'hA, 32'h0, 0,9,32'h1, 1,10,32'h1234,
                  32'h9, 32'h1234, 32'h1234, 2'b00, 2'b01};
      vecs[6] = '{0,1,0,3'b011, 2, 0, 3, 32'h5, 32'h0, 32'h0, 0,0,32'h0, 1,2,32'h77,
                  32'h77, 32'h0, 32'h0, 2'b01, 2'b00};
      vecs[7] = '{1,1,0,3'b000, 12, 13, 14, 32'hC, 32'hD, 32'h0, 0,12,32'h99, 1,13,32'h88,
                  32'hC, 32'h88, 32'h88, 2'b00, 2'b01};

      // Reset held two cycles while decode presents a valid instruction.
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(vecs[0]);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         chk_ctrl("reset", 1'b0, 1'b0, 5'd0, 3'b000);
         $display("reset cycle %0d e_valid=%0d e_rd=%0d", c, e_valid, e_rd);
      end

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         reset = 1'b0;
         drive(vecs[i]);
         @(posedge clk); #1;
         chk($sformatf("vec%0d.alu_a", i), alu_a, vecs[i].ea);
         chk($sformatf("vec%0d.alu_b", i), alu_b, vecs[i].eb);
         chk($sformatf("vec%0d.store", i), e_store_data, vecs[i].es);
         chk($sformatf("vec%0d.fwd_a", i), {30'b0, fwd_a}, {30'b0, vecs[i].fa});
         chk($sformatf("vec%0d.fwd_b", i), {30'b0, fwd_b}, {30'b0, vecs[i].fb});
         chk_ctrl($sformatf("vec%0d", i), vecs[i].valid, vecs[i].valid & vecs[i].regw,
                  vecs[i].rd, vecs[i].ctl);
         $display("vec %0d a=%h b=%h st=%h fa=%b fb=%b rd=%0d v=%0d",
                  i, alu_a, alu_b, e_store_data, fwd_a, fwd_b, e_rd, e_valid);
      end

      // Instruction A, then three stalled cycles with changing decode inputs.
      @(negedge clk);
      drive('{1,1,0,3'b001, 5, 6, 9, 32'h50, 32'h60, 32'h0, 0,0,32'h0, 0,0,32'h0,
              32'h0, 32'h0, 32'h0, 2'b00, 2'b00});
      @(posedge clk); #1;
      chk("loadA.alu_a", alu_a, 32'h50);
      chk_ctrl("loadA", 1'b1, 1'b1, 5'd9, 3'b001);
      $display("loadA a=%h rd=%0d", alu_a, e_rd);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         stall = 1'b1;
         d_valid = 1'b0; d_rs1 = 5'd1 + 5'(c); d_rd1 = $urandom; d_rd = 5'd2 + 5'(c);
         d_alu_control = 3'b010; d_reg_write = 1'b0;
         if (c == 1) begin
            w_reg_write = 1'b1; w_rd = 5'd5; w_result = 32'hC0FF_EE00;
         end
         @(posedge clk); #1;
         chk($sformatf("stall%0d.alu_a", c), alu_a, (c >= 1) ? 32'hC0FF_EE00 : 32'h50);
         chk($sformatf("stall%0d.fwd_a", c), {30'b0, fwd_a}, (c >= 1) ? 32'd1 : 32'd0);
         chk($sformatf("stall%0d.alu_b", c), alu_b, 32'h60);
         chk_ctrl($sformatf("stall%0d", c), 1'b1, 1'b1, 5'd9, 3'b001);
         $display("stall %0d a=%h fa=%b rd=%0d", c, alu_a, fwd_a, e_rd);
      end

      // Flush and stall together with a valid writing instruction: bubble wins.
      @(negedge clk);
      w_reg_write = 1'b0; stall = 1'b1; flush = 1'b1;
      d_valid = 1'b1; d_reg_write = 1'b1; d_rd = 5'd4; d_rd1 = 32'h1; d_rs1 = 5'd3;
      @(posedge clk); #1;
      chk_ctrl("flush_stall", 1'b0, 1'b0, 5'd0, 3'b000);
      chk("flush_stall.alu_a", alu_a, 32'h0);
      $display("flush+stall v=%0d rw=%0d rd=%0d", e_valid, e_reg_write, e_rd);

      // Load A again, then reset during a stall discards it.
      @(negedge clk);
      stall = 1'b0; flush = 1'b0;
      d_alu_control = 3'b011; d_rd = 5'd17;
      @(posedge clk); #1;
      chk_ctrl("reloadA", 1'b1, 1'b1, 5'd17, 3'b011);
      @(negedge clk);
      stall = 1'b1; reset = 1'b1;
      @(posedge clk); #1;
      chk_ctrl("reset_stall", 1'b0, 1'b0, 5'd0, 3'b000);
      $display("reset during stall v=%0d rd=%0d", e_valid, e_rd);

      // Flush alone after reset release.
      @(negedge clk);
      reset = 1'b0; stall = 1'b0;
      @(posedge clk); #1;
      chk_ctrl("post_reset_load", 1'b1, 1'b1, 5'd17, 3'b011);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      chk_ctrl("flush_only", 1'b0, 1'b0, 5'd0, 3'b000);
      $display("flush v=%0d rd=%0d", e_valid, e_rd);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding selection.
- Sits directly upstream of the 32-bit execute ALU and drives its a, b and 3-bit alu_control inputs.
- Captures decoded operands and control each cycle; supports stall (hold) and flush (bubble).
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB results.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register-index width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold all ID/EX state this cycle
- flush  in  1  load a bubble this cycle
- d_valid  in  1  decode slot holds a real instruction
- d_rd1  in  XLEN  register-file read data, rs1
- d_rd2  in  XLEN  register-file read data, rs2
- d_imm  in  XLEN  sign-extended immediate
- d_rs1  in  REGW  source index 1
- d_rs2  in  REGW  source index 2
- d_rd  in  REGW  destination index
- d_alu_control  in  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 101 slt)
- d_alu_src  in  1  1 = operand b is the immediate
- d_reg_write  in  1  instruction writes rd
- m_rd  in  REGW  EX/MEM destination
- m_reg_write  in  1  EX/MEM write enable
- m_result  in  XLEN  EX/MEM ALU result
- w_rd  in  REGW  MEM/WB destination
- w_reg_write  in  1  MEM/WB write enable
- w_result  in  XLEN  MEM/WB writeback value
- alu_a  out  XLEN  ALU operand a
- alu_b  out  XLEN  ALU operand b
- e_alu_control  out  3  registered ALU opcode
- e_store_data  out  XLEN  forwarded rs2 value, for stores
- e_rd  out  REGW  registered destination
- e_reg_write  out  1  registered write enable, gated by valid
- e_valid  out  1  EX slot valid
- fwd_a  out  2  debug: 00 = reg, 10 = EX/MEM, 01 = MEM/WB
- fwd_b  out  2  debug: same encoding, for the rs2 path

Behaviour:
- Reset (synchronous, active-high): every registered field cleared to 0, so e_valid = 0, e_reg_write = 0, e_rd = 0, e_alu_control = 000. Reset has priority over flush and stall. Reset asserted mid-stall discards the held instruction.
- Register update priority each rising clk: reset > flush > stall > load.
  - flush: e_valid = 0, e_reg_write = 0, e_rd = 0, e_alu_control = 000. Data fields are don't-care but cleared to 0 for determinism.
  - stall (no flush): all registered fields hold.
  - otherwise: all d_* fields are captured. e_valid = d_valid. e_reg_write = d_reg_write & d_valid.
  - flush and stall asserted together: flush wins.
- Latency: one cycle from d_* to e_*. Forwarding is combinational from the registered rs1/rs2 and the live m_/w_ inputs.
- Forwarding for source s (registered rs1 or rs2):
  - Select EX/MEM if m_reg_write and m_rd == s and s != 0.
  - Else select MEM/WB if w_reg_write and w_rd == s and s != 0.
  - Else use the registered read data.
  - EX/MEM has priority over MEM/WB when both match.
  - Register x0 is never forwarded; its path always returns the registered value, which is 0 from the register file.
- alu_a = forwarded rs1.
- alu_b = registered imm if the registered alu_src is 1, else forwarded rs2.
- e_store_data = forwarded rs2 regardless of alu_src.
- fwd_a and fwd_b report the selected path even when e_valid = 0.
- During stall, forwarding keeps re-evaluating against live m_/w_ inputs, so a result arriving mid-stall is picked up.
- No internal combinational path from the m_/w_ inputs to any register.

Decomposition:
- Shared package pipeline_pkg holds:
  - XLEN and REGW constants.
  - ALU opcode enum (ALU_ADD = 000, ALU_SUB = 001, ALU_AND = 010, ALU_OR = 011, ALU_SLT = 101).
  - Forward-select enum (FWD_REG = 00, FWD_MEM = 10, FWD_WB = 01).
- One sub-module, forward_mux, is instantiated twice (rs1 and rs2 paths). It takes src index, reg value and both m_/w_ triples, and returns the selected value and the select code.

Test Plan:
- Reset held 2 cycles with d_valid = 1 driven → e_valid = 0, e_reg_write = 0, e_rd = 0, e_alu_control = 000. First edge after release captures decode.
- Load rs1 = 3, rd1 = 0x10, alu_src = 1, imm = 0xFFFFFFFC, no hazards → next cycle alu_a = 0x10, alu_b = 0xFFFFFFFC, fwd_a = 00.
- Registered rs1 = 5, m_rd = 5, m_reg_write = 1, m_result = 0xAA, w_rd = 5, w_reg_write = 1, w_result = 0xBB → alu_a = 0xAA, fwd_a = 10. Drop m_reg_write → alu_a = 0xBB, fwd_a = 01.
- Registered rs2 = 0, m_rd = 0, m_reg_write = 1, m_result = 0x55 → alu_b = 0 (registered rd2), fwd_b = 00.
- Instruction A loaded, then stall = 1 for 3 cycles while d_* changes → e_* stays equal to A. Raise w_result match on A's rs1 during the stall → alu_a follows w_result.
- flush = 1 and stall = 1 in the same cycle with d_valid = 1, d_reg_write = 1 → next cycle e_valid = 0, e_reg_write = 0, e_rd = 0.
